// File: rtl/dpram_arbiter.sv
// rtl/dpram_arbiter.sv - two-client round-robin arbiter and sequencer for a dual-port RAM
// Independent write/read port arbitration, registered RAM issue, tagged read-data return.
module dpram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_a_req,
   input  logic                  i_a_we,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_wdata,
   output logic                  o_a_gnt,
   output logic                  o_a_rvalid,
   output logic [DATA_WIDTH-1:0] o_a_rdata,
   input  logic                  i_b_req,
   input  logic                  i_b_we,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_wdata,
   output logic                  o_b_gnt,
   output logic                  o_b_rvalid,
   output logic [DATA_WIDTH-1:0] o_b_rdata,
   output logic                  o_ram_valid,
   output logic                  o_ram_cs,
   output logic                  o_ram_wr_en,
   output logic                  o_ram_rd_en,
   output logic [ADDR_WIDTH-1:0] o_ram_wraddr,
   output logic [ADDR_WIDTH-1:0] o_ram_raddr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata,
   input  logic                  i_ram_ready
);

   localparam logic CL_A = 1'b0;
   localparam logic CL_B = 1'b1;

   logic                  wr_prio_q, wr_prio_d;
   logic                  rd_prio_q, rd_prio_d;
   logic                  ram_valid_q, ram_valid_d;
   logic                  ram_wr_en_q, ram_wr_en_d;
   logic                  ram_rd_en_q, ram_rd_en_d;
   logic [ADDR_WIDTH-1:0] ram_wraddr_q, ram_wraddr_d;
   logic [ADDR_WIDTH-1:0] ram_raddr_q, ram_raddr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LATENCY-1:0] tag_id_q, tag_id_d;
   logic                  a_rvalid_q, a_rvalid_d;
   logic                  b_rvalid_q, b_rvalid_d;
   logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

   logic                  ok, a_wr, a_rd, b_wr, b_rd;
   logic                  gnt_wa, gnt_wb, gnt_ra, gnt_rb;
   logic                  cand_ra, cand_rb, wr_any, rd_any;
   logic [ADDR_WIDTH-1:0] wr_addr_sel;

   // A read aimed at the address being written this cycle is held off so it sees the new data.
   always_comb begin
      ok          = ~i_rst & i_ram_ready;
      a_wr        = i_a_req & i_a_we;
      a_rd        = i_a_req & ~i_a_we;
      b_wr        = i_b_req & i_b_we;
      b_rd        = i_b_req & ~i_b_we;
      gnt_wa      = ok & a_wr & (~b_wr | (wr_prio_q == CL_A));
      gnt_wb      = ok & b_wr & (~a_wr | (wr_prio_q == CL_B));
      wr_any      = gnt_wa | gnt_wb;
      wr_addr_sel = gnt_wa ? i_a_addr : i_b_addr;
      cand_ra     = ok & a_rd & ~(wr_any & (i_a_addr == wr_addr_sel));
      cand_rb     = ok & b_rd & ~(wr_any & (i_b_addr == wr_addr_sel));
      gnt_ra      = cand_ra & (~cand_rb | (rd_prio_q == CL_A));
      gnt_rb      = cand_rb & (~cand_ra | (rd_prio_q == CL_B));
      rd_any      = gnt_ra | gnt_rb;
   end

   always_comb begin
      wr_prio_d = wr_prio_q;
      if (gnt_wa) begin
         wr_prio_d = CL_B;
      end else if (gnt_wb) begin
         wr_prio_d = CL_A;
      end
      rd_prio_d = rd_prio_q;
      if (gnt_ra) begin
         rd_prio_d = CL_B;
      end else if (gnt_rb) begin
         rd_prio_d = CL_A;
      end

      ram_valid_d  = wr_any | rd_any;
      ram_wr_en_d  = wr_any;
      ram_rd_en_d  = rd_any;
      ram_wraddr_d = ram_wraddr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_raddr_d  = ram_raddr_q;
      if (wr_any) begin
         ram_wraddr_d = wr_addr_sel;
         ram_wdata_d  = gnt_wa ? i_a_wdata : i_b_wdata;
      end
      if (rd_any) begin
         ram_raddr_d = gnt_ra ? i_a_addr : i_b_addr;
      end

      // Tag shift line; the rvalid register forms its final stage.
      tag_vld_d    = '0;
      tag_id_d     = '0;
      tag_vld_d[0] = rd_any;
      tag_id_d[0]  = gnt_rb;
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end

      a_rvalid_d = tag_vld_q[RD_LATENCY-1] & (tag_id_q[RD_LATENCY-1] == CL_A);
      b_rvalid_d = tag_vld_q[RD_LATENCY-1] & (tag_id_q[RD_LATENCY-1] == CL_B);
      a_rdata_d  = a_rvalid_d ? i_ram_rdata : a_rdata_q;
      b_rdata_d  = b_rvalid_d ? i_ram_rdata : b_rdata_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_prio_q    <= CL_A;
         rd_prio_q    <= CL_A;
         ram_valid_q  <= 1'b0;
         ram_wr_en_q  <= 1'b0;
         ram_rd_en_q  <= 1'b0;
         ram_wraddr_q <= '0;
         ram_raddr_q  <= '0;
         ram_wdata_q  <= '0;
         tag_vld_q    <= '0;
         tag_id_q     <= '0;
         a_rvalid_q   <= 1'b0;
         b_rvalid_q   <= 1'b0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
      end else begin
         wr_prio_q    <= wr_prio_d;
         rd_prio_q    <= rd_prio_d;
         ram_valid_q  <= ram_valid_d;
         ram_wr_en_q  <= ram_wr_en_d;
         ram_rd_en_q  <= ram_rd_en_d;
         ram_wraddr_q <= ram_wraddr_d;
         ram_raddr_q  <= ram_raddr_d;
         ram_wdata_q  <= ram_wdata_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
         a_rvalid_q   <= a_rvalid_d;
         b_rvalid_q   <= b_rvalid_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
      end
   end

   assign o_a_gnt      = gnt_wa | gnt_ra;
   assign o_b_gnt      = gnt_wb | gnt_rb;
   assign o_a_rvalid   = a_rvalid_q;
   assign o_b_rvalid   = b_rvalid_q;
   assign o_a_rdata    = a_rdata_q;
   assign o_b_rdata    = b_rdata_q;
   assign o_ram_valid  = ram_valid_q;
   assign o_ram_cs     = ram_valid_q;
   assign o_ram_wr_en  = ram_wr_en_q;
   assign o_ram_rd_en  = ram_rd_en_q;
   assign o_ram_wraddr = ram_wraddr_q;
   assign o_ram_raddr  = ram_raddr_q;
   assign o_ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb/tb_dpram_arbiter.sv - directed bench for dpram_arbiter with a read-return scoreboard
// Behavioural RAM answers reads combinationally, matching RD_LATENCY=1.
module tb_dpram_arbiter;

   localparam int AW     = 4;
   localparam int DW     = 8;
   localparam int RD_LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, a_we, b_req, b_we, ram_ready;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          ram_valid, ram_cs, ram_wr_en, ram_rd_en;
   logic [AW-1:0] ram_wraddr, ram_raddr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   typedef struct {
      logic          cl;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ram[16];
   logic [DW-1:0] model[16];
   logic [AW-1:0] hold_wa, hold_ra;
   logic [DW-1:0] hold_wd;
   int            cyc    = 0;
   int            errors = 0;
   int            checks = 0;
   logic          mon_en = 1'b0;

   always #5 clk = ~clk;

   dpram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RD_LAT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
      .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
      .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
      .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
      .o_ram_valid(ram_valid), .o_ram_cs(ram_cs), .o_ram_wr_en(ram_wr_en),
      .o_ram_rd_en(ram_rd_en), .o_ram_wraddr(ram_wraddr), .o_ram_raddr(ram_raddr),
      .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .i_ram_ready(ram_ready)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_wr_en === 1'b1) ram[ram_wraddr] <= ram_wdata;
   end
   assign ram_rdata = ram[ram_raddr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Read-return monitor: pops the scoreboard when an entry falls due.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.cl == 1'b0) begin
               chk("a_rvalid", a_rvalid, 1);
               chk("a_rdata", a_rdata, e.data);
               chk("b_rvalid_quiet", b_rvalid, 0);
            end else begin
               chk("b_rvalid", b_rvalid, 1);
               chk("b_rdata", b_rdata, e.data);
               chk("a_rvalid_quiet", a_rvalid, 0);
            end
         end else begin
            chk("no_rvalid", {a_rvalid, b_rvalid}, 0);
         end
      end
   end

   task automatic step(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic rdy, input logic ega, input logic egb);
      logic ewr, erd;
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      ram_ready = rdy;
      @(negedge clk);
      chk("a_gnt", a_gnt, ega);
      chk("b_gnt", b_gnt, egb);
      ewr = (ega & aw) | (egb & bw);
      erd = (ega & ~aw) | (egb & ~bw);
      if (rst) begin
         sb.delete();
         hold_wa = '0; hold_ra = '0; hold_wd = '0;
      end
      if (ega & ~aw) begin
         sb.push_back('{1'b0, model[aa], cyc + 1 + RD_LAT});
         hold_ra = aa;
      end
      if (egb & ~bw) begin
         sb.push_back('{1'b1, model[ba], cyc + 1 + RD_LAT});
         hold_ra = ba;
      end
      if (ega & aw) begin
         model[aa] = ad; hold_wa = aa; hold_wd = ad;
      end
      if (egb & bw) begin
         model[ba] = bd; hold_wa = ba; hold_wd = bd;
      end
      @(posedge clk);
      #1;
      chk("ram_valid", ram_valid, ewr | erd);
      chk("ram_cs", ram_cs, ewr | erd);
      chk("ram_wr_en", ram_wr_en, ewr);
      chk("ram_rd_en", ram_rd_en, erd);
      chk("ram_wraddr", ram_wraddr, hold_wa);
      chk("ram_raddr", ram_raddr, hold_ra);
      chk("ram_wdata", ram_wdata, hold_wd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with every request raised
      rst = 1'b1;
      step(1, 1, 4, 8'hA5, 1, 0, 3, 8'h00, 1, 0, 0);
      mon_en = 1'b1;
      step(1, 1, 4, 8'hA5, 1, 0, 3, 8'h00, 1, 0, 0);
      chk("reset_a_rdata", a_rdata, 0);
      chk("reset_b_rdata", b_rdata, 0);
      rst = 1'b0;

      // simultaneous writes alternate starting from A
      step(1, 1, 1, 8'h11, 1, 1, 2, 8'h22, 1, 1, 0);
      step(1, 1, 1, 8'h11, 1, 1, 2, 8'h22, 1, 0, 1);
      step(1, 1, 1, 8'h11, 1, 1, 2, 8'h22, 1, 1, 0);
      step(0, 0, 0, 8'h00, 1, 1, 2, 8'h22, 1, 0, 1);

      // A writes then reads back addr 4
      step(1, 1, 4, 8'hA5, 0, 0, 0, 8'h00, 1, 1, 0);
      step(1, 0, 4, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0);

      // A write and B read to different addresses in one cycle
      step(1, 1, 5, 8'h3C, 1, 0, 4, 8'h00, 1, 1, 1);

      // same-address collision: B deferred, then sees new data
      step(1, 1, 6, 8'h77, 1, 0, 6, 8'h00, 1, 1, 0);
      step(0, 0, 0, 8'h00, 1, 0, 6, 8'h00, 1, 0, 1);

      // simultaneous reads, back to back
      step(1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 1, 1, 0);
      step(0, 0, 0, 8'h00, 1, 0, 2, 8'h00, 1, 0, 1);

      // RAM not ready: nothing granted, write priority (B) preserved
      for (int i = 0; i < 3; i++) step(1, 1, 7, 8'h99, 1, 1, 8, 8'h88, 0, 0, 0);
      step(1, 1, 7, 8'h99, 1, 1, 8, 8'h88, 1, 0, 1);
      step(1, 1, 7, 8'h99, 0, 0, 0, 8'h00, 1, 1, 0);

      // reset with a read in flight; rd_prio is B before reset
      step(1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0);
      rst = 1'b1;
      step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
      rst = 1'b0;
      step(1, 0, 8, 8'h00, 1, 0, 7, 8'h00, 1, 1, 0);
      step(0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 1, 0, 1);

      for (int i = 0; i < 8 && sb.size() > 0; i++) step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
      step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
